// File: rtl/nios_fprint_scratchpad_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port scratchpad RAM (1-cycle read latency).
// Define NIOS_FPRINT_SCRATCHPAD_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module nios_fprint_scratchpad_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int BURST_W = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic [BURST_W-1:0]    m0_burstcount,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic [BURST_W-1:0]    m1_burstcount,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   input  logic [DATA_W-1:0]     ram_readdata
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t               r_state;
   logic                 r_owner;
   logic [ADDR_W-1:0]    r_addr;
   logic [BURST_W-1:0]   r_remaining;
   logic                 r_rd_pending;
   logic                 r_rd_owner;
`ifndef NIOS_FPRINT_SCRATCHPAD_ARB_FIXED_PRIO_EN
   logic                 r_last_grant;
`endif

   logic                 w_req0, w_req1, w_any_req;
   logic                 w_gnt;
   logic                 w_port;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic                 w_sel_write;
   logic [DATA_W-1:0]    w_sel_wdata;
   logic [BE_W-1:0]      w_sel_be;
   logic [BURST_W-1:0]   w_sel_bc;
   logic [BURST_W-1:0]   w_bc_eff;
   logic                 w_rd_issue;

   assign w_req0    = m0_read | m0_write;
   assign w_req1    = m1_read | m1_write;
   assign w_any_req = w_req0 | w_req1;

   always_comb begin
      w_gnt = 1'b0;
      if (w_req0 && w_req1) begin
`ifdef NIOS_FPRINT_SCRATCHPAD_ARB_FIXED_PRIO_EN
         w_gnt = 1'b0;
`else
         w_gnt = ~r_last_grant;
`endif
      end else if (w_req1) begin
         w_gnt = 1'b1;
      end
   end

   // Inside a burst the owner is locked; arbitration only matters in IDLE.
   assign w_port      = (r_state == IDLE) ? w_gnt : r_owner;
   assign w_sel_addr  = w_port ? m1_address    : m0_address;
   assign w_sel_write = w_port ? m1_write      : m0_write;
   assign w_sel_wdata = w_port ? m1_writedata  : m0_writedata;
   assign w_sel_be    = w_port ? m1_byteenable : m0_byteenable;
   assign w_sel_bc    = w_port ? m1_burstcount : m0_burstcount;
   assign w_bc_eff    = (w_sel_bc == '0) ? BURST_W'(1) : w_sel_bc;

   always_comb begin
      ram_address    = w_sel_addr;
      ram_writedata  = w_sel_wdata;
      ram_byteenable = w_sel_be;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      w_rd_issue     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               ram_chipselect = 1'b1;
               ram_write      = w_sel_write;
               w_rd_issue     = ~w_sel_write;
               if (w_gnt) m1_waitrequest = 1'b0;
               else       m0_waitrequest = 1'b0;
            end
         end
         WR_BURST: begin
            // Write low from the owner is a bubble: nothing issued, still not stalled.
            ram_address    = r_addr;
            ram_chipselect = w_sel_write;
            ram_write      = w_sel_write;
            if (r_owner) m1_waitrequest = 1'b0;
            else         m0_waitrequest = 1'b0;
         end
         RD_BURST: begin
            ram_address    = r_addr;
            ram_chipselect = 1'b1;
            w_rd_issue     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_addr       <= '0;
         r_remaining  <= '0;
         r_rd_pending <= 1'b0;
         r_rd_owner   <= 1'b0;
`ifndef NIOS_FPRINT_SCRATCHPAD_ARB_FIXED_PRIO_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         r_rd_pending <= w_rd_issue;
         r_rd_owner   <= w_port;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_gnt;
`ifndef NIOS_FPRINT_SCRATCHPAD_ARB_FIXED_PRIO_EN
                  r_last_grant <= w_gnt;
`endif
                  if (w_bc_eff > BURST_W'(1)) begin
                     r_addr      <= w_sel_addr + ADDR_W'(1);
                     r_remaining <= w_bc_eff - BURST_W'(1);
                     r_state     <= w_sel_write ? WR_BURST : RD_BURST;
                  end
               end
            end
            WR_BURST: begin
               if (w_sel_write) begin
                  r_addr      <= r_addr + ADDR_W'(1);
                  r_remaining <= r_remaining - BURST_W'(1);
                  if (r_remaining == BURST_W'(1)) r_state <= IDLE;
               end
            end
            RD_BURST: begin
               r_addr      <= r_addr + ADDR_W'(1);
               r_remaining <= r_remaining - BURST_W'(1);
               if (r_remaining == BURST_W'(1)) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read data fans out to both masters; only the valid strobe is steered.
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;
   assign m0_readdatavalid = r_rd_pending & ~r_rd_owner;
   assign m1_readdatavalid = r_rd_pending &  r_rd_owner;

endmodule
